// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling from a baud counter,
// valid/ack byte handoff with framing-error and overrun flags.
module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_BITS - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  logic [2:0]           state;
  logic                 rx_meta, rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 deliver;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      deliver   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      deliver <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          cnt   <= '0;
          state <= START;
        end
        START: if (cnt == CNT_HALF_END) begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= rx_s ? IDLE : DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == CNT_BIT_END) begin
          cnt   <= '0;
          shift <= {rx_s, shift[DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) state <= STOP;
          else bit_idx <= bit_idx + 1'b1;
        end else cnt <= cnt + 1'b1;
        // Leave at mid-stop-bit so a back-to-back start edge is not missed.
        STOP: if (cnt == CNT_BIT_END) begin
          cnt <= '0;
          if (rx_s) begin
            deliver   <= 1'b1;
            frame_err <= 1'b0;
            state     <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= BRK;
          end
        end else cnt <= cnt + 1'b1;
        BRK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Delivery wins over ack; an ack on the same edge only suppresses overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (deliver) begin
      data_out   <= shift;
      data_valid <= 1'b1;
      if (data_valid && !data_ack) overrun <= 1'b1;
      else if (data_valid && data_ack) overrun <= 1'b0;
    end else if (data_valid && data_ack) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit: latency, handshake,
// overrun, glitch rejection, framing error/break and mid-frame reset.
module tb_uart_rx;
  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst, rx, data_ack;
  logic [7:0] data_out;
  logic       data_valid, frame_err, overrun, busy;

  int total = 0;
  int bad   = 0;

  uart_rx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .data_valid(data_valid),
    .data_ack(data_ack), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
  endtask

  task automatic wait_valid(input int budget, output int lat);
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      if (data_valid) begin
        lat = c;
        return;
      end
    end
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1;
    tick(1);
    data_ack = 1'b0;
  endtask

  initial begin
    int lat;
    logic [7:0] exp2 [2];
    exp2[0] = 8'h3C;
    exp2[1] = 8'hC3;

    rst = 1'b0; rx = 1'b1; data_ack = 1'b0;
    tick(3);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    tick(3);

    // single frame, no ack
    fork
      send_frame(8'hA5, 1'b1);
      wait_valid(130, lat);
    join
    chk("a5_timeout", lat > 0, 1'b1);
    chk("a5_latency", lat >= 97 && lat <= 100, 1'b1);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_frame_err", frame_err, 1'b0);
    chk("a5_overrun", overrun, 1'b0);
    ack_pulse();
    chk("a5_ack_clears", data_valid, 1'b0);
    tick(5);

    // back-to-back frames, ack one cycle after each valid
    fork
      begin
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
      end
      for (int k = 0; k < 2; k++) begin
        int l2;
        wait_valid(200, l2);
        chk("b2b_timeout", l2 > 0, 1'b1);
        chk("b2b_data", data_out, exp2[k]);
        tick(1);
        chk("b2b_valid_cycle2", data_valid, 1'b1);
        ack_pulse();
        chk("b2b_valid_cleared", data_valid, 1'b0);
        chk("b2b_overrun", overrun, 1'b0);
      end
    join
    tick(5);

    // two frames without ack -> overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(15);
    chk("ovr_data", data_out, 8'h22);
    chk("ovr_valid", data_valid, 1'b1);
    chk("ovr_flag", overrun, 1'b1);
    ack_pulse();
    chk("ovr_ack_valid", data_valid, 1'b0);
    chk("ovr_ack_flag", overrun, 1'b0);
    tick(5);

    // short low glitch
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    chk("glitch_busy_high", busy, 1'b1);
    for (int c = 0; c < 8 && busy; c++) tick(1);
    chk("glitch_busy_drop", busy, 1'b0);
    chk("glitch_valid", data_valid, 1'b0);
    chk("glitch_frame_err", frame_err, 1'b0);
    chk("glitch_overrun", overrun, 1'b0);
    tick(5);

    // framing error then break then good frame
    send_frame(8'h55, 1'b0);
    tick(50);
    chk("fe_flag", frame_err, 1'b1);
    chk("fe_valid", data_valid, 1'b0);
    chk("fe_data_kept", data_out, 8'h22);
    chk("fe_break_busy", busy, 1'b1);
    rx = 1'b1;
    tick(5);
    chk("fe_break_exit", busy, 1'b0);
    send_frame(8'h0F, 1'b1);
    tick(15);
    chk("fe_next_data", data_out, 8'h0F);
    chk("fe_next_valid", data_valid, 1'b1);
    chk("fe_cleared", frame_err, 1'b0);
    ack_pulse();
    tick(5);

    // reset mid-data of 0x99
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h99 >> i) & 8'h01;
      tick(CPB);
    end
    chk("mid_busy_before", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_valid", data_valid, 1'b0);
    chk("mid_rst_frame_err", frame_err, 1'b0);
    chk("mid_rst_overrun", overrun, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    rx = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(CPB * 6);
    chk("mid_no_spurious", data_valid, 1'b0);
    send_frame(8'h77, 1'b1);
    tick(15);
    chk("mid_next_data", data_out, 8'h77);
    chk("mid_next_valid", data_valid, 1'b1);
    chk("mid_next_frame_err", frame_err, 1'b0);
    chk("mid_next_overrun", overrun, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
